// File: rtl/elastic_buffer_skp.sv
// Elastic buffer with SKP insert/delete for the receive symbol path; data_out is registered one cycle after rd_en.
// No backpressure: overflow/underflow pulse once and the buffer self-recovers via a one-cycle flush and refill.
module elastic_buffer_skp #(
    parameter int                DATA_W     = 10,
    parameter int                DEPTH      = 16,
    parameter logic [DATA_W-1:0] SKP_SYMBOL = 10'h0F4,
    parameter int                HI_MARK    = 10,
    parameter int                LO_MARK    = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     iRXVALID,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     oRXVALID,
    output logic                     SKP_ADDED,
    output logic                     SKP_REMOVED,
    output logic                     BUFF_OVERFLOW,
    output logic                     BUFF_UNDERFLOW,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DEPTH / 2);
    localparam logic [CNT_W-1:0] HI_C   = CNT_W'(HI_MARK);
    localparam logic [CNT_W-1:0] LO_C   = CNT_W'(LO_MARK);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                vld_q, vld_d;
    logic                add_q, add_d, rem_q, rem_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                push, pop;
    logic [DATA_W:0]     mem [DEPTH];
    logic [DATA_W:0]     head;

    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vld_d    = vld_q;
        add_d    = 1'b0;
        rem_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            FILL: begin
                push = wr_en;
                if (rd_en) begin
                    dout_d = SKP_SYMBOL;
                    vld_d  = 1'b0;
                end
            end
            RUN: begin
                // Read side is resolved first so a same-cycle pop frees the slot for a write at full.
                if (rd_en) begin
                    if (cnt_q == '0) begin
                        dout_d  = SKP_SYMBOL;
                        vld_d   = 1'b0;
                        unf_d   = 1'b1;
                        state_d = FLUSH;
                    end else if (cnt_q < LO_C && head == {1'b1, SKP_SYMBOL}) begin
                        dout_d = head[DATA_W-1:0];
                        vld_d  = 1'b1;
                        add_d  = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        dout_d = head[DATA_W-1:0];
                        vld_d  = head[DATA_W];
                    end
                end
                if (wr_en) begin
                    if (iRXVALID && data_in == SKP_SYMBOL && cnt_q > HI_C) begin
                        rem_d = 1'b1;
                    end else if (cnt_q == FULL_C && !pop) begin
                        ovf_d   = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (rd_en) begin
                    dout_d = SKP_SYMBOL;
                    vld_d  = 1'b0;
                end
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase

        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (state_q == FILL && cnt_d >= HALF_C) begin
            state_d = RUN;
        end
        if (state_q == FLUSH) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= SKP_SYMBOL;
            vld_q    <= 1'b0;
            add_q    <= 1'b0;
            rem_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            add_q    <= add_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= {iRXVALID, data_in};
        end
    end

    assign data_out       = dout_q;
    assign oRXVALID       = vld_q;
    assign SKP_ADDED      = add_q;
    assign SKP_REMOVED    = rem_q;
    assign BUFF_OVERFLOW  = ovf_q;
    assign BUFF_UNDERFLOW = unf_q;
    assign fill_level     = cnt_q;
endmodule
